// File: rtl/hud_pkg.sv
// Shared types and constants for the lives HUD: FSM states, colour indices and heart geometry.
package hud_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOSS_BLINK = 2'd1,
        GAIN_BLINK = 2'd2,
        GAMEOVER   = 2'd3
    } hud_state_t;

    typedef logic [1:0] color_t;

    localparam color_t NONE  = 2'd0;
    localparam color_t RED   = 2'd1;
    localparam color_t WHITE = 2'd2;
    localparam color_t GRAY  = 2'd3;

    localparam int SLOT_PITCH = 12;
    localparam int HEART_SIZE = 8;
    localparam int NUM_SLOTS  = 3;

    // Left edge of a slot in 11 bits; bit 10 set means the slot fell off the left of the screen.
    function automatic logic [10:0] slot_left(input logic [9:0] anchor, input logic [1:0] slot);
        return {1'b0, anchor} - 11'(SLOT_PITCH * slot);
    endfunction

endpackage

// File: rtl/heart_rom.sv
// 8x8 heart bitmap; column 0 is the MSB of each row.
module heart_rom (
    input  logic [2:0] i_row,
    output logic [7:0] o_bits
);

    always_comb begin
        case (i_row)
            3'd0:    o_bits = 8'b0110_0110;
            3'd1:    o_bits = 8'b1111_1111;
            3'd2:    o_bits = 8'b1111_1111;
            3'd3:    o_bits = 8'b1111_1111;
            3'd4:    o_bits = 8'b0111_1110;
            3'd5:    o_bits = 8'b0011_1100;
            3'd6:    o_bits = 8'b0001_1000;
            default: o_bits = 8'b0000_0000;
        endcase
    end

endmodule

// File: rtl/lives_hud.sv
// Lives HUD: up to three hearts drawn leftward from an anchor, blinking the slot that just
// changed and greying everything out with a flashing banner once the game is lost.
module lives_hud
    import hud_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_frame_clk,
    input  logic [1:0] i_lives_counter,
    input  logic       i_lose_game,
    input  logic [9:0] i_lives_x,
    input  logic [9:0] i_lives_y,
    input  logic [9:0] i_draw_x,
    input  logic [9:0] i_draw_y,
    output logic       o_is_heart,
    output logic [1:0] o_heart_color,
    output logic       o_gameover_flash
);

    logic       r_fsync1, r_fsync2, r_fsync3;
    logic       w_frame_tick;
    hud_state_t r_state;
    logic [1:0] r_prev_lives;
    logic [1:0] r_blink_slot;
    logic [4:0] r_frame_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fsync1 <= 1'b0;
            r_fsync2 <= 1'b0;
            r_fsync3 <= 1'b0;
        end else begin
            r_fsync1 <= i_frame_clk;
            r_fsync2 <= r_fsync1;
            r_fsync3 <= r_fsync2;
        end
    end

    assign w_frame_tick = r_fsync2 & ~r_fsync3;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_prev_lives <= 2'd3;
            r_blink_slot <= 2'd0;
            r_frame_cnt  <= 5'd0;
        end else if (w_frame_tick) begin
            r_prev_lives <= i_lives_counter;
            if (r_state == GAMEOVER) begin
                r_frame_cnt <= r_frame_cnt + 5'd1;
            end else if (i_lose_game) begin
                r_state     <= GAMEOVER;
                r_frame_cnt <= 5'd0;
            end else if (i_lives_counter < r_prev_lives) begin
                r_state      <= LOSS_BLINK;
                r_blink_slot <= i_lives_counter;
                r_frame_cnt  <= 5'd0;
            end else if (i_lives_counter > r_prev_lives) begin
                r_state      <= GAIN_BLINK;
                r_blink_slot <= i_lives_counter - 2'd1;
                r_frame_cnt  <= 5'd0;
            end else if (r_state != IDLE) begin
                // The counter wraps to 0 on the 32nd frame, leaving IDLE clean for the next blink.
                if (r_frame_cnt == 5'd31) begin
                    r_state <= IDLE;
                end
                r_frame_cnt <= r_frame_cnt + 5'd1;
            end
        end
    end

    logic [10:0]          w_dy;
    logic                 w_row_hit;
    logic [10:0]          w_left [NUM_SLOTS];
    logic [10:0]          w_dx   [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] w_hit_vec;

    assign w_dy      = {1'b0, i_draw_y} - {1'b0, i_lives_y};
    assign w_row_hit = (i_draw_y >= i_lives_y) && (w_dy < 11'(HEART_SIZE));

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        assign w_left[g]    = slot_left(i_lives_x, 2'(g));
        assign w_dx[g]      = {1'b0, i_draw_x} - w_left[g];
        assign w_hit_vec[g] = ~w_left[g][10]
                              && ({1'b0, i_draw_x} >= w_left[g])
                              && (w_dx[g] < 11'(HEART_SIZE));
    end

    logic       w_slot_hit;
    logic [1:0] w_slot_idx;
    logic [2:0] w_col;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_slot_hit = 1'b0;
        w_slot_idx = 2'd0;
        w_col      = 3'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (w_hit_vec[i]) begin
                w_slot_hit = 1'b1;
                w_slot_idx = 2'(i);
                w_col      = w_dx[i][2:0];
            end
        end
    end

    logic [7:0] w_rom_bits;
    logic       w_pixel_on;
    logic       w_is_heart;

    heart_rom u_heart_rom (
        .i_row  (w_dy[2:0]),
        .o_bits (w_rom_bits)
    );

    assign w_pixel_on = w_rom_bits[3'd7 - w_col];
    assign w_is_heart = w_row_hit & w_slot_hit & w_pixel_on;

    color_t w_color;

    always_comb begin
        w_color = (w_slot_idx < i_lives_counter) ? RED : GRAY;
        case (r_state)
            GAMEOVER:   w_color = GRAY;
            LOSS_BLINK: if (w_slot_idx == r_blink_slot) w_color = r_frame_cnt[2] ? GRAY : RED;
            GAIN_BLINK: if (w_slot_idx == r_blink_slot) w_color = r_frame_cnt[2] ? RED : WHITE;
            default:    ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_is_heart    <= 1'b0;
            o_heart_color <= NONE;
        end else begin
            o_is_heart    <= w_is_heart;
            o_heart_color <= w_is_heart ? w_color : NONE;
        end
    end

    assign o_gameover_flash = (r_state == GAMEOVER) & ~r_frame_cnt[4];

endmodule

// File: doc/lives_hud.md
LIVES_HUD -- requirements
Module: lives_hud

Interface
REQ-001 Clk  input  1  system pixel clock; all state updates on its rising edge.
REQ-002 Reset  input  1  asynchronous, active-high reset.
REQ-003 frame_clk  input  1  vertical-sync-rate signal; sampled as data and never used as a clock.
REQ-004 lives_counter  input  2  current life count, 0..3, from the lives tracker.
REQ-005 lose_game  input  1  game-over flag, sticky until Reset.
REQ-006 LivesX, LivesY  input  10 each  upper-left anchor of heart slot 0.
REQ-007 DrawX, DrawY  input  10 each  current VGA pixel coordinate.
REQ-008 is_heart  output  1  current pixel lies on a heart bitmap "on" bit.
REQ-009 heart_color  output  2  colour index: 0 none, 1 red, 2 white, 3 gray.
REQ-010 gameover_flash  output  1  game-over banner enable, blinking.

Function
REQ-011 frame_clk SHALL pass through a 2-flop synchronizer; frame_tick SHALL pulse for one Clk cycle when the synchronized value is 1 and was 0 on the previous cycle.
REQ-012 prev_lives (2 bit) SHALL load lives_counter on every frame_tick.
REQ-013 Heart slot i (i = 0,1,2) SHALL cover x in [LivesX - 12*i, LivesX - 12*i + 7] and y in [LivesY, LivesY + 7].
REQ-014 Slot-geometry arithmetic SHALL be 11-bit.
REQ-015 A slot whose left edge underflows below 0 SHALL never draw.
REQ-016 The pixel bit SHALL come from an 8x8 bitmap addressed by row = DrawY - LivesY and col = DrawX - slot left edge.
REQ-017 is_heart SHALL equal the slot-hit AND bitmap bit for that pixel.
REQ-018 heart_color SHALL be 0 whenever is_heart is 0.
REQ-019 is_heart and heart_color SHALL be registered, one Clk latency from DrawX/DrawY.
REQ-020 The FSM SHALL have exactly the states IDLE, LOSS_BLINK, GAIN_BLINK and GAMEOVER.
REQ-021 FSM transitions and evaluation SHALL occur only on frame_tick.
REQ-022 IDLE colouring: slot i < lives_counter SHALL be red (1); all other slots SHALL be gray (3).
REQ-023 IDLE -> LOSS_BLINK SHALL occur when lives_counter < prev_lives; blink_slot SHALL be set to lives_counter and frame_cnt cleared.
REQ-024 IDLE -> GAIN_BLINK SHALL occur when lives_counter > prev_lives; blink_slot SHALL be set to lives_counter - 1 and frame_cnt cleared.
REQ-025 In LOSS_BLINK, blink_slot SHALL be red when frame_cnt[2] = 0 and gray otherwise.
REQ-026 In GAIN_BLINK, blink_slot SHALL be white when frame_cnt[2] = 0 and red otherwise.
REQ-027 In both blink states, the remaining slots SHALL follow the IDLE colouring rule.
REQ-028 frame_cnt (5 bit) SHALL increment on each frame_tick in the blink states.
REQ-029 A blink state SHALL return to IDLE on the tick where frame_cnt = 31, for 32 frames total.
REQ-030 A new loss or gain detected during a blink state SHALL restart the blink with the new blink_slot and frame_cnt = 0.
REQ-031 lose_game = 1 on a frame_tick SHALL force GAMEOVER from any state.
REQ-032 lose_game SHALL take priority over a simultaneous count change.
REQ-033 In GAMEOVER, all slots SHALL be gray.
REQ-034 In GAMEOVER, gameover_flash SHALL equal NOT frame_cnt[4], with frame_cnt free-running.
REQ-035 GAMEOVER SHALL be exited only by Reset.
REQ-036 gameover_flash SHALL be 0 in every state except GAMEOVER.

Reset
REQ-037 On Reset the block SHALL enter IDLE with prev_lives = 3, frame_cnt = 0, blink_slot = 0, both synchronizer flops = 0, is_heart = 0, heart_color = 0 and gameover_flash = 0.
REQ-038 Reset asserted mid-blink or in GAMEOVER SHALL abort immediately, with no frame_tick generated by the first synchronized high after release unless a true 0->1 edge is seen.

Structure
REQ-039 The hud_state_t enum, colour-index constants (NONE, RED, WHITE, GRAY), slot pitch (12) and heart size (8) SHALL reside in a shared package hud_pkg.
REQ-040 The 8x8 bitmap SHALL be a combinational sub-module heart_rom (row 3 bit in, row bits 8 out).

Verification
REQ-041 Reset, then 3 lives at anchor (608,17) -> red hearts at x 608-615, 596-603 and 584-591; is_heart asserted one cycle after the DrawX/DrawY match.
REQ-042 Step lives 3 -> 2 -> slot 2 alternates red/gray every 4 ticks for 32 ticks, then stays gray.
REQ-043 Step lives 2 -> 3 -> slot 2 alternates white/red for 32 ticks, then stays red.
REQ-044 Drop lives 3 -> 2, then 2 -> 1 on tick 10 -> blink moves to slot 1 and runs a full 32 ticks from the change.
REQ-045 Set lives -> 0 and lose_game = 1 on the same tick -> GAMEOVER, all slots gray, gameover_flash high for 16 ticks then low for 16.
REQ-046 Set LivesX = 10 -> slots 1 and 2 never drive is_heart.
REQ-047 Assert Reset during GAMEOVER -> all outputs go to 0 asynchronously.
